// File: rtl/fir_sequencer.sv
// FIR run sequencer: streams L coefficients and N samples from external RAMs,
// runs one multiply-accumulate per cycle, and writes saturated Q15 results.
module fir_sequencer #(
    parameter int WSP_MAX = 32,
    parameter int ACC_W   = 38
) (
    input  logic        clk_b,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [5:0]  Ile_wsp,
    input  logic [13:0] Ile_probek,
    output logic        pracuje,
    output logic        DONE,
    output logic        FSM_MUX_CDC,
    output logic [4:0]  address_FIR,
    input  logic [15:0] wsp_data,
    output logic [13:0] probka_adres,
    input  logic [15:0] probka_data,
    output logic [15:0] wynik,
    output logic [13:0] wynik_adres,
    output logic        wynik_wr
);

    localparam int KW = (WSP_MAX > 1) ? $clog2(WSP_MAX) : 1;
    localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] C_MIN = -(ACC_W'(32768));

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_FLUSH, S_WRITE} state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_start_q;
    logic                     r_armed;
    logic [KW-1:0]            r_k;
    logic [KW-1:0]            r_lm1;
    logic [13:0]              r_n;
    logic [13:0]              r_nm1;
    logic                     r_issue_q;
    logic                     r_pad_q;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_done;

    logic                     w_start_edge;
    logic [KW:0]              w_l;
    logic                     w_run_ok;
    logic                     w_last_k;
    logic                     w_last_n;
    logic signed [31:0]       w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_sh;
    logic [15:0]              w_sat;

    // r_armed blocks a Start that is already high when reset releases.
    assign w_start_edge = Start & ~r_start_q & r_armed;
    assign w_l          = (int'(Ile_wsp) > WSP_MAX) ? (KW+1)'(WSP_MAX) : (KW+1)'(Ile_wsp);
    assign w_run_ok     = (w_l != '0) && (Ile_probek != 14'd0);
    assign w_last_k     = (r_k == r_lm1);
    assign w_last_n     = (r_n == r_nm1);

    assign w_prod     = $signed(wsp_data) * $signed(probka_data);
    assign w_prod_ext = {{(ACC_W-32){w_prod[31]}}, w_prod};
    assign w_sh       = r_acc >>> 15;

    always_comb begin
        w_sat = w_sh[15:0];
        if (w_sh > C_MAX) begin
            w_sat = 16'h7FFF;
        end else if (w_sh < C_MIN) begin
            w_sat = 16'h8000;
        end
    end

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_edge && w_run_ok) w_next = S_MAC;
            S_MAC:   if (w_last_k) w_next = S_FLUSH;
            S_FLUSH: w_next = S_WRITE;
            S_WRITE: w_next = w_last_n ? S_IDLE : S_MAC;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q <= 1'b0;
            r_armed   <= 1'b0;
            r_k       <= '0;
            r_lm1     <= '0;
            r_n       <= '0;
            r_nm1     <= '0;
            r_issue_q <= 1'b0;
            r_pad_q   <= 1'b0;
            r_acc     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_start_q <= Start;
            if (!Start) r_armed <= 1'b1;
            r_issue_q <= (r_state == S_MAC);
            r_pad_q   <= (14'(r_k) > r_n);
            // Data for an address issued last cycle is on the inputs now.
            if (r_issue_q && !r_pad_q) r_acc <= r_acc + w_prod_ext;
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        if (!w_run_ok) begin
                            r_done <= 1'b1;
                        end else begin
                            r_done <= 1'b0;
                            r_n    <= '0;
                            r_k    <= '0;
                            r_acc  <= '0;
                            r_lm1  <= KW'(w_l - 1'b1);
                            r_nm1  <= Ile_probek - 14'd1;
                        end
                    end
                end
                S_MAC: r_k <= r_k + 1'b1;
                S_WRITE: begin
                    r_acc <= '0;
                    r_k   <= '0;
                    if (w_last_n) r_done <= 1'b1;
                    else          r_n    <= r_n + 14'd1;
                end
                default: ;
            endcase
        end
    end

    assign pracuje      = (r_state != S_IDLE);
    assign FSM_MUX_CDC  = ~pracuje;
    assign DONE         = r_done;
    assign address_FIR  = (r_state == S_MAC) ? 5'(r_k) : 5'd0;
    assign probka_adres = (r_state == S_MAC) ? (r_n - 14'(r_k)) : 14'd0;
    assign wynik_wr     = (r_state == S_WRITE);
    assign wynik        = (r_state == S_WRITE) ? w_sat : 16'd0;
    assign wynik_adres  = (r_state == S_WRITE) ? r_n : 14'd0;

endmodule

// File: doc/fir_sequencer.md
FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 SHALL have parameter WSP_MAX, default 32, maximum tap count (coefficient RAM depth).
REQ-002 SHALL have parameter ACC_W, default 38, signed accumulator width.
REQ-003 SHALL have port clk_b  input  1  single clock, rising edge; all state in this domain.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port Start  input  1  run request from ctrl_registers; its rising edge triggers a run.
REQ-006 SHALL have port Ile_wsp  input  6  tap count L.
REQ-007 SHALL have port Ile_probek  input  14  sample count N.
REQ-008 SHALL have port pracuje  output  1  run in progress; gates bus RAM writes externally.
REQ-009 SHALL have port DONE  output  1  sticky run-complete flag.
REQ-010 SHALL have port FSM_MUX_CDC  output  1  coefficient-RAM owner: 1 = bus address, 0 = address_FIR.
REQ-011 SHALL have port address_FIR  output  5  coefficient RAM read address.
REQ-012 SHALL have port wsp_data  input  16  signed Q15 coefficient, valid 1 cycle after address_FIR.
REQ-013 SHALL have port probka_adres  output  14  input-sample memory read address.
REQ-014 SHALL have port probka_data  input  16  signed Q15 sample, valid 1 cycle after probka_adres.
REQ-015 SHALL have port wynik  output  16  signed Q15 output sample.
REQ-016 SHALL have port wynik_adres  output  14  output-sample memory write address.
REQ-017 SHALL have port wynik_wr  output  1  one-cycle write strobe for wynik/wynik_adres.

Function
REQ-018 SHALL compute y[n] = sum over k = 0..L-1 of h[k]*x[n-k] for n = 0..N-1, with x[n-k] = 0 when n < k.
REQ-019 SHALL detect a Start rising edge with a registered Start_q; Start held high SHALL NOT retrigger; Start edges during a run SHALL be ignored.
REQ-020 SHALL latch L and N at the start edge; later Ile_wsp/Ile_probek changes SHALL NOT affect the run; L > WSP_MAX SHALL be clamped to WSP_MAX.
REQ-021 SHALL implement states IDLE, MAC, FLUSH, WRITE.
REQ-022 IDLE: start edge with L=0 or N=0 -> set DONE on the next edge, stay IDLE, no wynik_wr; otherwise clear DONE, set n=0, k=0, acc=0 -> MAC.
REQ-023 MAC: address_FIR=k, probka_adres=n-k, register a pad flag (n<k); k++ each cycle; after issuing k=L-1 -> FLUSH.
REQ-024 Each cycle after an issue cycle SHALL add wsp_data*probka_data to acc (signed 32-bit product, sign-extended to ACC_W), or add 0 if the delayed pad flag is set.
REQ-025 FLUSH: accumulate the last product -> WRITE.
REQ-026 WRITE: wynik = saturate(acc >>> 15) to [0x8000, 0x7FFF] (arithmetic shift, truncation); wynik_adres=n; wynik_wr=1 for this cycle only; clear acc, k=0; if n=N-1 -> set DONE, go IDLE; else n++ -> MAC.
REQ-027 pracuje SHALL be 1 exactly in MAC/FLUSH/WRITE: N*(L+2) cycles, starting on the edge after the start edge; DONE SHALL rise on the same edge pracuje falls.
REQ-028 FSM_MUX_CDC SHALL equal !pracuje; address_FIR and probka_adres SHALL be 0 outside MAC.
REQ-029 DONE SHALL stay 1 until the next valid start edge or reset.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, pracuje=0, DONE=0, FSM_MUX_CDC=1, wynik_wr=0, wynik=0, wynik_adres=0, address_FIR=0, probka_adres=0, acc=0, Start_q=0.
REQ-031 Reset mid-run SHALL abandon the run with no further wynik_wr; after release, Start already high SHALL NOT trigger until it goes low then high.

Verification
REQ-032 L=3, h={0x4000,0x2000,0x1000}, N=4, x={0x7FFF,0,0,0} -> wynik={0x3FFF,0x1FFF,0x0FFF,0x0000} at addresses 0..3; pracuje high for 20 cycles; DONE=1 afterwards.
REQ-033 L=2, h={0x7FFF,0x7FFF}, x={0x7FFF,0x7FFF} -> y={0x7FFE,0x7FFF (saturated)}; h={0x8000,0x8000}, same x -> y1=0x8000 (saturated).
REQ-034 Ile_wsp=0, Ile_probek=5, Start edge -> DONE=1 on the next edge, pracuje never 1, no wynik_wr.
REQ-035 Ile_wsp=40, N=2 -> run as L=32, pracuje high for 68 cycles, address_FIR sweeps 0..31 per sample.
REQ-036 rst_n pulsed low during MAC of sample 1 -> all outputs at reset values the same cycle, FSM_MUX_CDC=1, no wynik_wr for sample 1.
REQ-037 Start held high after DONE -> no restart; Start low then high -> DONE clears and a new run begins.
